// File: rtl/pfvf_sched_pkg.sv
// Shared types and the port-to-function map for the PF/VF request scheduler.
package pfvf_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int CNT_W = 8;

  // Index i of each map belongs to requester port i (port 7 is the MSB entry).
  localparam logic [7:0][2:0]  PF_MAP = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
  localparam logic [7:0][10:0] VF_MAP = {11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd2, 11'd1, 11'd0};
  localparam logic [7:0]       VA_MAP = 8'b1000_0110;

endpackage

// File: rtl/pfvf_rd_credit.sv
// Outstanding-read counter for one requester port; flags completions that arrive with nothing outstanding.
module pfvf_rd_credit
  import pfvf_sched_pkg::*;
#(
  parameter int MAX_RD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic avail,
  output logic underflow
);

  logic [CNT_W-1:0] cnt;

  assign avail     = (cnt < CNT_W'(MAX_RD));
  assign underflow = dec && (cnt == '0);

  // A completion against an empty counter is dropped, but a same-cycle issue still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   if (cnt != '0) cnt <= cnt - 1'b1;
        2'b11:   if (cnt == '0) cnt <= cnt + 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pfvf_req_sched.sv
// Round-robin, packet-atomic scheduler of per-function request ports onto one shared channel,
// with per-port outstanding-read throttling and PF/VF tagging from a fixed function map.
module pfvf_req_sched
  import pfvf_sched_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 512,
  parameter int MAX_RD    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        cfg_port_en,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_last,
  input  logic [NUM_PORTS-1:0]        req_is_rd,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [DATA_W-1:0]           out_data,
  output logic [2:0]                  out_port,
  output logic [2:0]                  out_pf,
  output logic [10:0]                 out_vf,
  output logic                        out_va,
  input  logic                        cpl_valid,
  input  logic [2:0]                  cpl_port,
  output logic                        err_cpl_ovf
);

  state_t               state, state_nxt;
  logic [2:0]           grant, grant_nxt, rr_ptr, pick;
  logic                 found, first_beat, in_grant, beat_acc, pkt_done, cpl_oob;
  logic [NUM_PORTS-1:0] elig, avail, underflow;
  logic [7:0]           elig8, valid8, last8, rd8, ready8, inc8, dec8;
  logic [DATA_W-1:0]    data_arr [8];

  // Pad per-port vectors to the 3-bit port index space so indexing is width-clean.
  assign elig   = req_valid & cfg_port_en & (~req_is_rd | avail);
  assign elig8  = 8'(elig);
  assign valid8 = 8'(req_valid);
  assign last8  = 8'(req_last);
  assign rd8    = 8'(req_is_rd);

  for (genvar g = 0; g < 8; g++) begin : g_lane
    if (g < NUM_PORTS) begin : g_used
      assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign data_arr[g] = '0;
    end
  end

  always_comb begin
    int         idx;
    logic [2:0] ix;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    ix    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_PORTS;
      ix  = 3'(idx);
      if (!found && elig8[ix]) begin
        found = 1'b1;
        pick  = ix;
      end
    end
  end

  // Handshake: a beat moves when out_valid && out_ready; only the granted port sees
  // req_ready, which mirrors out_ready while in GRANT and is 0 otherwise.
  assign in_grant  = (state == ST_GRANT);
  assign out_valid = in_grant && valid8[grant];
  assign out_last  = in_grant && last8[grant];
  assign out_data  = data_arr[grant];
  assign ready8    = (in_grant && out_ready) ? (8'b1 << grant) : 8'b0;
  assign req_ready = ready8[NUM_PORTS-1:0];
  assign beat_acc  = out_valid && out_ready;
  assign pkt_done  = beat_acc && out_last;

  assign out_port = in_grant ? grant         : 3'd0;
  assign out_pf   = in_grant ? PF_MAP[grant] : 3'd0;
  assign out_vf   = in_grant ? VF_MAP[grant] : 11'd0;
  assign out_va   = in_grant && VA_MAP[grant];

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt = ST_GRANT;
          grant_nxt = pick;
        end
      end
      ST_GRANT: begin
        if (pkt_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cpl_oob = cpl_valid && !(int'(cpl_port) < NUM_PORTS);
  assign inc8    = (in_grant && first_beat && beat_acc && rd8[grant]) ? (8'b1 << grant) : 8'b0;
  assign dec8    = (cpl_valid && !cpl_oob) ? (8'b1 << cpl_port) : 8'b0;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_credit
    pfvf_rd_credit #(.MAX_RD(MAX_RD)) u_credit (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc8[g]),
      .dec       (dec8[g]),
      .avail     (avail[g]),
      .underflow (underflow[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      first_beat  <= 1'b0;
      err_cpl_ovf <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      err_cpl_ovf <= err_cpl_ovf || (|underflow) || cpl_oob;
      if (state == ST_IDLE && found) first_beat <= 1'b1;
      else if (beat_acc)             first_beat <= 1'b0;
      if (pkt_done) rr_ptr <= (int'(grant) == NUM_PORTS - 1) ? 3'd0 : grant + 3'd1;
    end
  end

endmodule

// File: tb/tb_pfvf_req_sched.sv
// Directed bench for pfvf_req_sched: cycle-vector table plus hand sequences for throttling,
// credit corner cases, backpressure and mid-packet reset.
module tb_pfvf_req_sched;

  localparam int NP = 8;
  localparam int DW = 512;
  localparam int MR = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    cfg_port_en = '0, req_valid = '0, req_last = '0, req_is_rd = '0;
  logic [NP-1:0]    req_ready;
  logic [NP*DW-1:0] req_data;
  logic             out_valid, out_last, out_va, err_cpl_ovf;
  logic             out_ready = 1'b0, cpl_valid = 1'b0;
  logic [DW-1:0]    out_data;
  logic [2:0]       out_port, out_pf, cpl_port = '0;
  logic [10:0]      out_vf;
  logic [DW-1:0]    pdata [NP];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign req_data[g*DW +: DW] = pdata[g];
  end

  pfvf_req_sched #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_RD(MR)) dut (
    .clk(clk), .rst(rst), .cfg_port_en(cfg_port_en), .req_valid(req_valid),
    .req_ready(req_ready), .req_last(req_last), .req_is_rd(req_is_rd), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_data(out_data),
    .out_port(out_port), .out_pf(out_pf), .out_vf(out_vf), .out_va(out_va),
    .cpl_valid(cpl_valid), .cpl_port(cpl_port), .err_cpl_ovf(err_cpl_ovf)
  );

  typedef struct {
    logic [7:0] en, valid, last, rd;
    logic       ordy, cv;
    logic [2:0] cp;
    logic       ov;
    logic [2:0] op;
    logic [7:0] rr;
    logic       ol, err;
  } vec_t;

  function automatic vec_t mv(input logic [7:0] en, valid, last, rd, input logic ordy, cv,
                              input logic [2:0] cp, input logic ov, input logic [2:0] op,
                              input logic [7:0] rr, input logic ol, err);
    vec_t t;
    t.en = en; t.valid = valid; t.last = last; t.rd = rd; t.ordy = ordy; t.cv = cv; t.cp = cp;
    t.ov = ov; t.op = op; t.rr = rr; t.ol = ol; t.err = err;
    return t;
  endfunction

  function automatic logic [DW-1:0] mk_data(input int p, input logic [7:0] tag);
    return {16{8'hA5, 8'(p), tag, 8'h5A}};
  endfunction

  // Function map as stated for the default configuration.
  function automatic logic [2:0] e_pf(input logic [2:0] p);
    case (p)
      3'd3: return 3'd1;
      3'd4: return 3'd2;
      3'd5: return 3'd3;
      3'd6: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [10:0] e_vf(input logic [2:0] p);
    case (p)
      3'd1: return 11'd1;
      3'd2: return 11'd2;
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic e_va(input logic [2:0] p);
    return (p == 3'd1) || (p == 3'd2) || (p == 3'd7);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t t, input logic [7:0] tag, input string name);
    logic [DW-1:0] exp_d;
    @(negedge clk);
    cfg_port_en = t.en; req_valid = t.valid; req_last = t.last; req_is_rd = t.rd;
    out_ready = t.ordy; cpl_valid = t.cv; cpl_port = t.cp;
    for (int p = 0; p < NP; p++) pdata[p] = mk_data(p, tag);
    #1;
    chk({name, " out_valid"}, 64'(out_valid), 64'(t.ov));
    chk({name, " req_ready"}, 64'(req_ready), 64'(t.rr));
    chk({name, " err_cpl_ovf"}, 64'(err_cpl_ovf), 64'(t.err));
    if (t.ov) begin
      chk({name, " out_port"}, 64'(out_port), 64'(t.op));
      chk({name, " out_last"}, 64'(out_last), 64'(t.ol));
      chk({name, " out_pf"}, 64'(out_pf), 64'(e_pf(t.op)));
      chk({name, " out_vf"}, 64'(out_vf), 64'(e_vf(t.op)));
      chk({name, " out_va"}, 64'(out_va), 64'(e_va(t.op)));
      exp_d = mk_data(int'(t.op), tag);
      n_tests++;
      if (out_data !== exp_d) begin
        n_fail++;
        $display("FAIL %s out_data: got %h expected %h", name, out_data, exp_d);
      end
    end
  endtask

  task automatic chk_quiet(input string name, input logic exp_err);
    chk({name, " out_valid"}, 64'(out_valid), 64'd0);
    chk({name, " req_ready"}, 64'(req_ready), 64'd0);
    chk({name, " out_port"}, 64'(out_port), 64'd0);
    chk({name, " out_pf"}, 64'(out_pf), 64'd0);
    chk({name, " out_vf"}, 64'(out_vf), 64'd0);
    chk({name, " out_va"}, 64'(out_va), 64'd0);
    chk({name, " err_cpl_ovf"}, 64'(err_cpl_ovf), 64'(exp_err));
  endtask

  vec_t tbl[$];

  initial begin
    for (int p = 0; p < NP; p++) pdata[p] = mk_data(p, 8'h00);

    // Reset state, with every port pushing so the gating is visible.
    cfg_port_en = '1; req_valid = '1; req_last = '1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset", 1'b0);
    cfg_port_en = '0; req_valid = '0; req_last = '0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Round robin over ports 0,3,5, then a 4-beat port-1 packet, then enable handling.
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 1, 0, 8'h01, 1, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 1, 3, 8'h08, 1, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 1, 5, 8'h20, 1, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 1, 0, 8'h01, 1, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 1, 3, 8'h08, 1, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h29, 8'h29, 8'h00, 1, 0, 0, 1, 5, 8'h20, 1, 0));
    tbl.push_back(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h02, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h02, 8'h00, 8'h00, 1, 0, 0, 1, 1, 8'h02, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h03, 8'h00, 8'h00, 1, 0, 0, 1, 1, 8'h02, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h03, 8'h00, 8'h00, 1, 0, 0, 1, 1, 8'h02, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h03, 8'h02, 8'h00, 1, 0, 0, 1, 1, 8'h02, 1, 0));
    tbl.push_back(mv(8'hFF, 8'h01, 8'h01, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h01, 8'h01, 8'h00, 1, 0, 0, 1, 0, 8'h01, 1, 0));
    tbl.push_back(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFE, 8'h01, 8'h01, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFE, 8'h01, 8'h01, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFF, 8'h04, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mv(8'hFB, 8'h04, 8'h00, 8'h00, 1, 0, 0, 1, 2, 8'h04, 0, 0));
    tbl.push_back(mv(8'hFB, 8'h04, 8'h04, 8'h00, 1, 0, 0, 1, 2, 8'h04, 1, 0));
    tbl.push_back(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], 8'(i), $sformatf("tbl[%0d]", i));

    // Read throttle on port 2 with two credits.
    apply_vec(mv(8'hFF, 8'h04, 8'h04, 8'h04, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h20, "rd0");
    apply_vec(mv(8'hFF, 8'h04, 8'h04, 8'h04, 1, 0, 0, 1, 2, 8'h04, 1, 0), 8'h21, "rd1");
    apply_vec(mv(8'hFF, 8'h04, 8'h04, 8'h04, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h22, "rd2");
    apply_vec(mv(8'hFF, 8'h04, 8'h04, 8'h04, 1, 0, 0, 1, 2, 8'h04, 1, 0), 8'h23, "rd3");
    apply_vec(mv(8'hFF, 8'h04, 8'h04, 8'h04, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h24, "rd_held0");
    apply_vec(mv(8'hFF, 8'h04, 8'h04, 8'h04, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h25, "rd_held1");
    apply_vec(mv(8'hFF, 8'h04, 8'h04, 8'h04, 1, 1, 2, 0, 0, 8'h00, 0, 0), 8'h26, "rd_cpl");
    apply_vec(mv(8'hFF, 8'h04, 8'h04, 8'h04, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h27, "rd_arb");
    apply_vec(mv(8'hFF, 8'h04, 8'h04, 8'h04, 1, 0, 0, 1, 2, 8'h04, 1, 0), 8'h28, "rd_third");
    apply_vec(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 1, 2, 0, 0, 8'h00, 0, 0), 8'h29, "rd_drain0");
    apply_vec(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 1, 2, 0, 0, 8'h00, 0, 0), 8'h2A, "rd_drain1");

    // Port 4: issue and completion in the same cycle keep the count at 1.
    apply_vec(mv(8'hFF, 8'h10, 8'h10, 8'h10, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h40, "cr0");
    apply_vec(mv(8'hFF, 8'h10, 8'h10, 8'h10, 1, 0, 0, 1, 4, 8'h10, 1, 0), 8'h41, "cr1");
    apply_vec(mv(8'hFF, 8'h10, 8'h10, 8'h10, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h42, "cr2");
    apply_vec(mv(8'hFF, 8'h10, 8'h10, 8'h10, 1, 1, 4, 1, 4, 8'h10, 1, 0), 8'h43, "cr_same");
    apply_vec(mv(8'hFF, 8'h10, 8'h10, 8'h10, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h44, "cr4");
    apply_vec(mv(8'hFF, 8'h10, 8'h10, 8'h10, 1, 0, 0, 1, 4, 8'h10, 1, 0), 8'h45, "cr5");
    apply_vec(mv(8'hFF, 8'h10, 8'h10, 8'h10, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h46, "cr_full0");
    apply_vec(mv(8'hFF, 8'h10, 8'h10, 8'h10, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h47, "cr_full1");
    apply_vec(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 1, 4, 0, 0, 8'h00, 0, 0), 8'h48, "cr_drain0");
    apply_vec(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 1, 4, 0, 0, 8'h00, 0, 0), 8'h49, "cr_drain1");
    apply_vec(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 1, 6, 0, 0, 8'h00, 0, 0), 8'h4A, "ovf_cpl");
    apply_vec(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1), 8'h4B, "ovf_set");
    apply_vec(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1), 8'h4C, "ovf_sticky");

    // Port 3 multi-beat packet stalled for 5 cycles, then reset mid-packet.
    apply_vec(mv(8'hFF, 8'h08, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1), 8'h30, "bp_arb");
    apply_vec(mv(8'hFF, 8'h08, 8'h00, 8'h00, 1, 0, 0, 1, 3, 8'h08, 0, 1), 8'h30, "bp_beat0");
    for (int i = 0; i < 5; i++)
      apply_vec(mv(8'hFF, 8'h08, 8'h00, 8'h00, 0, 0, 0, 1, 3, 8'h00, 0, 1), 8'h31,
                $sformatf("bp_stall%0d", i));
    apply_vec(mv(8'hFF, 8'h08, 8'h00, 8'h00, 1, 0, 0, 1, 3, 8'h08, 0, 1), 8'h31, "bp_beat1");
    apply_vec(mv(8'hFF, 8'h4A, 8'h42, 8'h00, 1, 0, 0, 1, 3, 8'h08, 0, 1), 8'h32, "bp_beat2");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("mid_rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({"post_rst", " out_valid"}, 64'(out_valid), 64'd0);
    apply_vec(mv(8'hFF, 8'h4A, 8'h42, 8'h00, 1, 0, 0, 1, 1, 8'h02, 1, 0), 8'h50, "post_rst_grant");
    apply_vec(mv(8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0), 8'h51, "post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pfvf_req_sched.md
PFVF_REQ_SCHED -- requirements
Module: pfvf_req_sched

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 8, giving the number of function requester ports (range 2..8).
REQ-002 The block SHALL have parameter DATA_W, default 512, giving the request beat width.
REQ-003 The block SHALL have parameter MAX_RD, default 16, giving the maximum outstanding reads per port (range 1..255).
REQ-004 Port clk, input, 1: the single clock.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port cfg_port_en, input, NUM_PORTS: per-port enable; a disabled port is never granted.
REQ-007 Port req_valid, input, NUM_PORTS: per-port beat valid.
REQ-008 Port req_ready, output, NUM_PORTS: per-port beat accept.
REQ-009 Port req_last, input, NUM_PORTS: per-port last beat of the packet.
REQ-010 Port req_is_rd, input, NUM_PORTS: packet is a read; sampled on the first beat.
REQ-011 Port req_data, input, NUM_PORTS*DATA_W: per-port beat data, with port i at bits [i*DATA_W +: DATA_W].
REQ-012 Port out_valid, output, 1: shared-channel beat valid.
REQ-013 Port out_ready, input, 1: shared-channel accept.
REQ-014 Port out_last, output, 1: last beat.
REQ-015 Port out_data, output, DATA_W: beat data.
REQ-016 Port out_port, output, 3: index of the granted port.
REQ-017 Port out_pf, output, 3: PF number from the function map.
REQ-018 Port out_vf, output, 11: VF number from the function map.
REQ-019 Port out_va, output, 1: VF-active flag from the function map.
REQ-020 Port cpl_valid, input, 1: read completion returned.
REQ-021 Port cpl_port, input, 3: port owning the completion.
REQ-022 Port err_cpl_ovf, output, 1: sticky flag for a completion received with no read outstanding.

Function
REQ-023 The block SHALL implement a two-state FSM, IDLE and GRANT.
REQ-024 A port SHALL be eligible when req_valid=1, cfg_port_en=1, and either req_is_rd=0 or rd_cnt[port] < MAX_RD.
REQ-025 In IDLE, if any port is eligible, the block SHALL register the first eligible port at or after rr_ptr (modulo NUM_PORTS) as the grant and go to GRANT; otherwise it SHALL stay in IDLE.
- Arbitration latency is 1 cycle: out_valid is never asserted in IDLE.
REQ-026 In GRANT, out_valid, out_data, out_last and req_ready SHALL pass through combinationally for the granted port only.
- out_valid = req_valid[g].
- req_ready[g] = out_ready.
- req_ready of every other port is 0.
REQ-027 out_port, out_pf, out_vf and out_va SHALL be driven from the registered grant and the function map for the whole packet.
REQ-028 The grant SHALL be packet-atomic, leaving GRANT only on a beat with out_valid & out_ready & out_last.
- On that beat: go to IDLE and set rr_ptr = g+1 mod NUM_PORTS.
REQ-029 Deasserting cfg_port_en mid-packet SHALL NOT abort the packet; the bit is checked at arbitration only.
REQ-030 rd_cnt[port] SHALL increment on acceptance of the first beat of a read packet.
REQ-031 rd_cnt[cpl_port] SHALL decrement on cpl_valid.
- Simultaneous increment and decrement on the same port leaves the count unchanged.
REQ-032 cpl_valid with rd_cnt[cpl_port]=0 SHALL leave the count at 0 and set err_cpl_ovf until reset.
- Same-cycle increment on that port still increments.
REQ-033 cpl_port >= NUM_PORTS SHALL set err_cpl_ovf and change no count.

Reset
REQ-034 On rst, the block SHALL force state IDLE, rr_ptr=0, all rd_cnt=0, and err_cpl_ovf=0.
REQ-035 During reset, out_valid=0 and req_ready=0, and out_port, out_pf, out_vf and out_va are 0.
REQ-036 Reset asserted mid-packet SHALL drop the grant; the next arbitration after deassertion starts from port 0.

Structure
REQ-037 Package pfvf_sched_pkg SHALL hold the function map constants (per-port PF, VF and VA arrays) and the state enum.
- Default map: port0 = PF0/VF0/VA0, port1 = PF0/VF1/VA1, port2 = PF0/VF2/VA1, port3 = PF1, port4 = PF2, port5 = PF3, port6 = PF4, port7 = PF0/VF0/VA1.
REQ-038 Sub-module pfvf_rd_credit SHALL hold one port's read counter, with inc/dec/err logic, instantiated NUM_PORTS times.

Verification
REQ-039 Round-robin fairness: ports 0, 3 and 5 each hold a continuous single-beat packet stream, out_ready=1 -> grants run 0,3,5,0,3,5, each beat 2 cycles apart.
REQ-040 Packet atomicity: port 1 sends a 4-beat packet and port 0 requests on the 2nd beat -> 4 contiguous port-1 beats, out_pf=0, out_vf=1, out_va=1, then port 0.
REQ-041 Read throttle: MAX_RD=2, port 2 issues 3 reads -> the 3rd read is held until cpl_valid with cpl_port=2, and is issued 2 cycles later.
REQ-042 Simultaneous credit events: first read beat on port 4 with cpl_port=4 in the same cycle and rd_cnt=1 -> rd_cnt stays 1; cpl_port=6 with rd_cnt=0 -> err_cpl_ovf=1 and stays 1.
REQ-043 Backpressure and reset: out_ready=0 for 5 cycles mid-packet -> data is held stable and req_ready=0; rst pulsed mid-packet -> out_valid=0 within the same cycle, and the next grant goes to the lowest eligible port.
